// File: rtl/ladder_xz.sv
// Montgomery-ladder scalar multiplier over GF(2^233) (B-233), López-Dahab projective x-only.
// Four digit-serial field multipliers are shared across the ladder step; squaring is combinational.

module ladder_xz_gfmul #(
  parameter int W   = 233,
  parameter int TAP = 74,
  parameter int DIG = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic [W-1:0] p
);
  localparam int NDIG = (W + DIG - 1) / DIG;
  localparam int BW   = NDIG * DIG;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_e;

  mstate_e        st_q, st_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   c_q, c_d;
  logic [BW-1:0]  b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // MSB-first digit step: c <- c * x^DIG + a * d  (mod x^W + x^TAP + 1)
  function automatic logic [W-1:0] mac_digit(input logic [W-1:0] c, input logic [W-1:0] av,
                                             input logic [DIG-1:0] d);
    logic [W-1:0] r;
    logic         msb;
    r = c;
    for (int j = DIG - 1; j >= 0; j--) begin
      msb = r[W-1];
      r   = {r[W-2:0], 1'b0};
      if (msb) begin
        r[0]   = ~r[0];
        r[TAP] = ~r[TAP];
      end
      if (d[j]) r = r ^ av;
    end
    return r;
  endfunction

  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    case (st_q)
      M_IDLE: begin
        if (en) begin
          a_d   = a;
          b_d   = BW'(b);
          c_d   = '0;
          cnt_d = CW'(NDIG);
          st_d  = M_RUN;
        end
      end
      M_RUN: begin
        if (!en) begin
          st_d = M_IDLE;
        end else begin
          c_d   = mac_digit(c_q, a_q, b_q[BW-1 -: DIG]);
          b_d   = b_q << DIG;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) st_d = M_DONE;
        end
      end
      M_DONE: begin
        if (!en) st_d = M_IDLE;
      end
      default: st_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= M_IDLE;
    else     st_q <= st_d;
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    c_q   <= c_d;
    cnt_q <= cnt_d;
  end

  assign ready = (st_q == M_DONE);
  assign p     = c_q;
endmodule

module ladder_xz #(
  parameter int           W      = 233,
  parameter logic [W-1:0] B_COEF = 233'h066647EDE6C332C7F8C0923BB58213B333B20E9CE4281FE115F7D8F90AD,
  parameter int           TAP    = 74,
  parameter int           DIG    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] k,
  output logic         busy,
  output logic         rdy,
  output logic [W-1:0] X1,
  output logic [W-1:0] Z1,
  output logic [W-1:0] X2,
  output logic [W-1:0] Z2
);
  localparam int           IW  = $clog2(W);
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_NEXT, S_MUL1, S_UPD1, S_MUL2, S_UPD2, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  i_q, i_d;
  logic           bit_q, bit_d;
  logic [3:0]     got_q, got_d;
  logic [W-1:0]   x0_q, x0_d, k_q, k_d;
  logic [W-1:0]   x1_q, x1_d, z1_q, z1_d, x2_q, x2_d, z2_q, z2_d;
  logic [W-1:0]   za_q, za_d;
  logic [W-1:0]   prod_q [4];
  logic [W-1:0]   prod_d [4];

  logic [3:0]     mul_en, mul_rdy, hit;
  logic [W-1:0]   mul_a [4];
  logic [W-1:0]   mul_b [4];
  logic [W-1:0]   mul_p [4];
  logic [W-1:0]   xd, zd, xa_new;

  function automatic logic [W-1:0] gf_sqr(input logic [W-1:0] a);
    logic [2*W-2:0] s;
    s = '0;
    for (int j = 0; j < W; j++) s[2*j] = a[j];
    for (int j = 2*W - 2; j >= W; j--) begin
      if (s[j]) begin
        s[j-W]     = ~s[j-W];
        s[j-W+TAP] = ~s[j-W+TAP];
        s[j]       = 1'b0;
      end
    end
    return s[W-1:0];
  endfunction

  // bit=1 doubles (X2,Z2) and adds into (X1,Z1); bit=0 the reverse
  assign xd     = bit_q ? x2_q : x1_q;
  assign zd     = bit_q ? z2_q : z1_q;
  assign hit    = mul_en & mul_rdy;
  assign xa_new = prod_q[0] ^ prod_q[1];

  always_comb begin
    mul_en = 4'b0000;
    mul_a  = '{x1_q, x2_q, B_COEF, gf_sqr(xd)};
    mul_b  = '{z2_q, z1_q, gf_sqr(gf_sqr(zd)), gf_sqr(zd)};
    if (state_q == S_MUL1) begin
      mul_en = ~got_q;
    end else if (state_q == S_MUL2) begin
      mul_en   = {2'b00, ~got_q[1:0]};
      mul_a[0] = x0_q;
      mul_b[0] = za_q;
      mul_a[1] = prod_q[0];
      mul_b[1] = prod_q[1];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_mul
    ladder_xz_gfmul #(.W(W), .TAP(TAP), .DIG(DIG)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .en    (mul_en[g]),
      .a     (mul_a[g]),
      .b     (mul_b[g]),
      .ready (mul_rdy[g]),
      .p     (mul_p[g])
    );
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    bit_d   = bit_q;
    got_d   = got_q;
    x0_d    = x0_q;
    k_d     = k_q;
    x1_d    = x1_q;
    z1_d    = z1_q;
    x2_d    = x2_q;
    z2_d    = z2_q;
    za_d    = za_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x0_d    = x0;
          k_d     = k;
          i_d     = IW'(W - 1);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (k_q[i_q]) begin
          x1_d    = x0_q;
          z1_d    = ONE;
          x2_d    = gf_sqr(gf_sqr(x0_q)) ^ B_COEF;
          z2_d    = gf_sqr(x0_q);
          state_d = S_NEXT;
        end else if (i_q == '0) begin
          x1_d    = ONE;
          z1_d    = '0;
          x2_d    = x0_q;
          z2_d    = ONE;
          state_d = S_DONE;
        end else begin
          i_d = i_q - 1'b1;
        end
      end
      S_NEXT: begin
        if (i_q == '0) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q - 1'b1;
          bit_d   = k_q[i_q - 1'b1];
          got_d   = 4'b0000;
          state_d = S_MUL1;
        end
      end
      S_MUL1: begin
        for (int j = 0; j < 4; j++) if (hit[j]) prod_d[j] = mul_p[j];
        got_d = got_q | hit;
        if ((got_q | hit) == 4'b1111) begin
          got_d   = 4'b0000;
          state_d = S_UPD1;
        end
      end
      S_UPD1: begin
        za_d = gf_sqr(prod_q[0] ^ prod_q[1]);
        if (bit_q) begin
          x2_d = gf_sqr(gf_sqr(x2_q)) ^ prod_q[2];
          z2_d = prod_q[3];
        end else begin
          x1_d = gf_sqr(gf_sqr(x1_q)) ^ prod_q[2];
          z1_d = prod_q[3];
        end
        state_d = S_MUL2;
      end
      S_MUL2: begin
        // T1/T2 are consumed when unit 1 loads, so T5/T6 may overwrite slots 0/1
        for (int j = 0; j < 2; j++) if (hit[j]) prod_d[j] = mul_p[j];
        got_d = got_q | hit;
        if ((got_q[1:0] | hit[1:0]) == 2'b11) begin
          got_d   = 4'b0000;
          state_d = S_UPD2;
        end
      end
      S_UPD2: begin
        if (bit_q) begin
          x1_d = xa_new;
          z1_d = za_q;
        end else begin
          x2_d = xa_new;
          z2_d = za_q;
        end
        state_d = S_NEXT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      bit_q   <= 1'b0;
      got_q   <= 4'b0000;
      x1_q    <= '0;
      z1_q    <= '0;
      x2_q    <= '0;
      z2_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      bit_q   <= bit_d;
      got_q   <= got_d;
      x1_q    <= x1_d;
      z1_q    <= z1_d;
      x2_q    <= x2_d;
      z2_q    <= z2_d;
    end
  end

  always_ff @(posedge clk) begin
    x0_q   <= x0_d;
    k_q    <= k_d;
    za_q   <= za_d;
    prod_q <= prod_d;
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign rdy  = (state_q == S_DONE);
  assign X1   = x1_q;
  assign Z1   = z1_q;
  assign X2   = x2_q;
  assign Z2   = z2_q;
endmodule
